// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg: shared state encoding, div_op bit positions and width defaults for the iterative divider.
package div_ctrl_pkg;
    localparam int DIV_W_DEF = 32;
    localparam int CNT_W_DEF = 6;
    localparam int OP_QUO    = 0;
    localparam int OP_REM    = 1;
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;
endpackage

// File: rtl/div_step.sv
// div_step: one restoring radix-2 division step on unsigned magnitudes.
module div_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] rem_i,
    input  logic [W-1:0] quo_i,
    input  logic [W-1:0] dsor_i,
    output logic [W-1:0] rem_o,
    output logic [W-1:0] quo_o
);
    logic [W:0] shifted;
    logic       ge;
    always_comb begin
        shifted = {rem_i, quo_i[W-1]};
        ge      = shifted >= {1'b0, dsor_i};
        rem_o   = ge ? W'(shifted - {1'b0, dsor_i}) : shifted[W-1:0];
        quo_o   = {quo_i[W-2:0], ge};
    end
endmodule

// File: rtl/div_ctrl.sv
// div_ctrl: multi-cycle signed/unsigned divider controller, one quotient bit per cycle.
// The quotient register starts out holding |dividend| and shifts it out as quotient bits shift in.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_enable,
    input  logic             div_sign,
    input  logic [1:0]       div_op,
    input  logic [DIV_W-1:0] div_src1,
    input  logic [DIV_W-1:0] div_src2,
    input  logic             div_ack,
    input  logic             div_flush,
    output logic             div_complete,
    output logic [DIV_W-1:0] div_result,
    output logic             div_busy
);
    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [DIV_W-1:0]   rem_q, quo_q, dsor_q, result_q;
    logic [DIV_W-1:0]   rem_d, quo_d, res_d, q_fix, r_fix, a_abs, b_abs;
    logic [1:0]         op_q;
    logic               neg_q_q, neg_r_q, complete_q, busy_q, a_neg, b_neg;

    div_step #(.W(DIV_W)) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dsor_i(dsor_q),
        .rem_o (rem_d),
        .quo_o (quo_d)
    );

    always_comb begin
        a_neg = div_sign & div_src1[DIV_W-1];
        b_neg = div_sign & div_src2[DIV_W-1];
        a_abs = a_neg ? -div_src1 : div_src1;
        b_abs = b_neg ? -div_src2 : div_src2;
        // divide-by-zero yields all ones; the remainder path naturally restores the dividend
        q_fix = (dsor_q == '0) ? '1 : (neg_q_q ? -quo_q : quo_q);
        r_fix = neg_r_q ? -rem_q : rem_q;
        res_d = op_q[OP_QUO] ? q_fix : (op_q[OP_REM] ? r_fix : '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dsor_q     <= '0;
            result_q   <= '0;
            op_q       <= '0;
            neg_q_q    <= 1'b0;
            neg_r_q    <= 1'b0;
            complete_q <= 1'b0;
            busy_q     <= 1'b0;
        end else if (div_flush) begin
            state_q    <= IDLE;
            complete_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (div_enable) begin
                    rem_q   <= '0;
                    quo_q   <= a_abs;
                    dsor_q  <= b_abs;
                    neg_q_q <= a_neg ^ b_neg;
                    neg_r_q <= a_neg;
                    op_q    <= div_op;
                    cnt_q   <= '0;
                    busy_q  <= 1'b1;
                    state_q <= CALC;
                end
                CALC: begin
                    rem_q   <= rem_d;
                    quo_q   <= quo_d;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(DIV_W - 1)) state_q <= FIX;
                end
                FIX: begin
                    result_q   <= res_d;
                    complete_q <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= DONE;
                end
                DONE: if (div_ack) begin
                    complete_q <= 1'b0;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign div_complete = complete_q;
    assign div_result   = result_q;
    assign div_busy     = busy_q;
endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: directed checks of latency, results, corner cases, handshake, flush and async reset.
module tb_div_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        div_enable = 1'b0, div_sign = 1'b0, div_ack = 1'b0, div_flush = 1'b0;
    logic [1:0]  div_op = 2'b00;
    logic [31:0] div_src1 = '0, div_src2 = '0;
    logic        div_complete, div_busy;
    logic [31:0] div_result;
    int          checks = 0, errors = 0, seen;

    div_ctrl dut (
        .clk(clk), .reset(reset), .div_enable(div_enable), .div_sign(div_sign),
        .div_op(div_op), .div_src1(div_src1), .div_src2(div_src2), .div_ack(div_ack),
        .div_flush(div_flush), .div_complete(div_complete), .div_result(div_result),
        .div_busy(div_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Issue one request at a negedge, scramble operands after it is taken, expect completion in cycle 34.
    task automatic do_op(input string tag, input logic s, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp,
                         input int hold);
        int n;
        div_sign = s; div_op = op; div_src1 = a; div_src2 = b; div_enable = 1'b1;
        step();
        div_src1 = $urandom; div_src2 = $urandom;
        chk({tag, "_busy"}, 32'(div_busy), 32'd1);
        n = 1;
        while (!div_complete && n < 60) begin
            step();
            n++;
        end
        chk({tag, "_lat"}, n, 32'd34);
        chk({tag, "_res"}, div_result, exp);
        for (int i = 0; i < hold; i++) begin
            step();
            chk({tag, "_hold_cmp"}, 32'(div_complete), 32'd1);
            chk({tag, "_hold_res"}, div_result, exp);
        end
        div_ack = 1'b1;
        step();
        div_ack = 1'b0; div_enable = 1'b0;
        chk({tag, "_idle"}, {30'd0, div_busy, div_complete}, 32'd0);
    endtask

    initial begin
        #1;
        chk("rst_cmp", 32'(div_complete), 32'd0);
        chk("rst_busy", 32'(div_busy), 32'd0);
        chk("rst_res", div_result, 32'd0);
        step(); step();
        reset = 1'b1;
        step();

        do_op("s100d7_q", 1'b1, 2'b01, 32'd100, 32'd7, 32'd14, 0);
        do_op("s100d7_r", 1'b1, 2'b10, 32'd100, 32'd7, 32'd2, 0);
        do_op("sm7d2_q", 1'b1, 2'b01, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0);
        do_op("sm7d2_r", 1'b1, 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0);
        do_op("uffd2_q", 1'b0, 2'b01, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 0);
        do_op("uffd2_r", 1'b0, 2'b10, 32'hFFFF_FFFF, 32'd2, 32'd1, 0);
        do_op("div0_q", 1'b1, 2'b01, 32'h1234, 32'd0, 32'hFFFF_FFFF, 0);
        do_op("div0_r", 1'b1, 2'b10, 32'h1234, 32'd0, 32'h1234, 0);
        do_op("ovf_q", 1'b1, 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
        do_op("ovf_r", 1'b1, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);
        do_op("op00", 1'b0, 2'b00, 32'd50, 32'd3, 32'd0, 0);
        do_op("hold5", 1'b0, 2'b01, 32'd1000, 32'd10, 32'd100, 5);

        div_sign = 1'b0; div_op = 2'b01; div_src1 = 32'd77; div_src2 = 32'd5; div_enable = 1'b1;
        for (int i = 0; i < 11; i++) step();
        div_flush = 1'b1; div_enable = 1'b0;
        step();
        div_flush = 1'b0;
        chk("flush_idle", {30'd0, div_busy, div_complete}, 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (div_complete || div_busy) seen++;
        end
        chk("flush_quiet", seen, 32'd0);
        do_op("post_flush", 1'b0, 2'b10, 32'd77, 32'd5, 32'd2, 0);

        div_sign = 1'b1; div_op = 2'b01; div_src1 = 32'd500; div_src2 = 32'd4; div_enable = 1'b1;
        for (int i = 0; i < 6; i++) step();
        #2 reset = 1'b0;
        #1;
        chk("arst_out", {div_result[29:0], div_busy, div_complete}, 32'd0);
        @(negedge clk);
        div_enable = 1'b0;
        reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (div_complete || div_busy) seen++;
        end
        chk("arst_quiet", seen, 32'd0);
        do_op("post_rst", 1'b1, 2'b01, 32'd500, 32'hFFFF_FFFC, 32'hFFFF_FF83, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 SHALL provide parameter DIV_W, default 32, operand/result width.
REQ-002 SHALL provide parameter CNT_W, default 6, iteration counter width.
REQ-003 SHALL have: clk  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have: reset  in  1  asynchronous, active-low reset; 0 clears all state immediately.
REQ-005 SHALL have: div_enable  in  1  request, held high by execute stage until result consumed.
REQ-006 SHALL have: div_sign  in  1  1 = signed (div.w/mod.w), 0 = unsigned (div.wu/mod.wu).
REQ-007 SHALL have: div_op  in  2  bit0 = quotient wanted, bit1 = remainder wanted.
REQ-008 SHALL have: div_src1  in  DIV_W  dividend.
REQ-009 SHALL have: div_src2  in  DIV_W  divisor.
REQ-010 SHALL have: div_ack  in  1  execute stage hands instruction to memory stage this cycle.
REQ-011 SHALL have: div_flush  in  1  cancel in-flight operation.
REQ-012 SHALL have: div_complete  out  1  result valid, held until ack.
REQ-013 SHALL have: div_result  out  DIV_W  quotient or remainder selected by div_op.
REQ-014 SHALL have: div_busy  out  1  high in CALC or FIX.

Function
REQ-015 SHALL implement states IDLE, CALC, FIX, DONE.
REQ-016 IDLE: div_enable=1 and div_flush=0 -> latch |src1|, |src2|, sign flags, div_op; counter=0; go CALC.
REQ-017 CALC: one restoring radix-2 step per cycle; after 32 steps (counter==31) go FIX.
REQ-018 FIX: apply signs (quotient negative iff operand signs differ, remainder takes dividend sign), select by div_op, register div_result; go DONE.
REQ-019 DONE: div_complete=1, div_result stable; div_ack=1 -> IDLE.
REQ-020 Latency: first cycle enable seen in IDLE = cycle 0; div_complete high from cycle 34.
REQ-021 Enable still high in cycle after ack SHALL start new operation only via IDLE (no result reuse, min one IDLE cycle).
REQ-022 div_flush in any state SHALL return to IDLE next edge, div_complete low; flush overrides ack and enable.
REQ-023 Divisor 0: quotient 0xFFFFFFFF, remainder = original dividend, same latency.
REQ-024 Signed 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0.
REQ-025 Operands changing after IDLE->CALC SHALL not affect result.
REQ-026 div_op==0 with enable: operation runs, div_result=0.

Reset
REQ-027 Reset low: state IDLE, counter 0, div_complete 0, div_busy 0, div_result 0, internal registers 0.
REQ-028 Reset mid-CALC/DONE SHALL abort; no complete after release until a new request.

Structure
REQ-029 Shared package/header SHALL hold state encodings, DIV_OP bit positions, DIV_W/CNT_W defaults.
REQ-030 One sub-module div_step (combinational: remainder, quotient, divisor in -> next remainder/quotient) SHALL be instantiated once.

Verification
REQ-031 Signed 100/7, div_op=01 -> complete cycle 34, result 14; div_op=10 -> 2.
REQ-032 Signed -7/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; unsigned 0xFFFFFFFF/2 -> 0x7FFFFFFF, remainder 1.
REQ-033 Divisor 0, dividend 0x1234 -> quotient 0xFFFFFFFF, remainder 0x1234; signed 0x80000000/-1 -> 0x80000000, 0.
REQ-034 Ack withheld 5 cycles after complete -> complete and result held constant; ack -> IDLE, no restart that cycle.
REQ-035 Flush at cycle 10 of CALC -> IDLE next cycle, complete never asserted; new request completes normally.
REQ-036 Reset pulsed low mid-CALC -> outputs 0 immediately (asynchronous), IDLE after release.
